// File: rtl/unary_shift_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : unary_mac_pkg
//  Description : Shared types and width helpers for the unary multiply-
//                accumulate datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package unary_mac_pkg;

  // Top-level sequencing: gather operands, fold products, stream the result.
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } mac_state_e;

  // Unary length for a given binary operand width.
  function automatic int u_bits(input int bin_bits);
    return 1 << bin_bits;
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : unary_mac_pkg
`default_nettype wire

// File: rtl/unary_shift_mac_lane_counter.sv
`default_nettype none
// ============================================================================
//  Module      : unary_lane_counter
//  Description : Saturating count of ones on one serial unary wire, with
//                synchronous clear and count enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module unary_lane_counter
  import unary_mac_pkg::*;
#(
  parameter int BIN_BITS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic              bit_in,
  output logic [BIN_BITS:0] cnt
);

  localparam logic [BIN_BITS:0] c_u = (BIN_BITS + 1)'(u_bits(BIN_BITS));

  logic [BIN_BITS:0] r_cnt;

  // Count ones on accepted beats; values beyond the unary length are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && bit_in && (r_cnt != c_u)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule : unary_lane_counter
`default_nettype wire

// File: rtl/unary_shift_mac.sv
`default_nettype none
// ============================================================================
//  Module      : unary_shift_mac
//  Description : Multi-lane unary multiply-accumulate. Per-lane unary operand
//                counts are multiplied lane by lane into a saturating binary
//                accumulator, and the total is replayed as a unary stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module unary_shift_mac
  import unary_mac_pkg::*;
#(
  parameter int BIN_BITS = 4,
  parameter int LANES    = 4,
  parameter int ACC_BITS = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] in_a,
  input  logic [LANES-1:0] in_b,
  input  logic             in_last,
  input  logic             in_acc,
  output logic             out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_sat
);

  localparam int c_cnt_w  = BIN_BITS + 1;
  localparam int c_prod_w = 2 * c_cnt_w;
  localparam int c_sum_w  = ((ACC_BITS > c_prod_w) ? ACC_BITS : c_prod_w) + 1;
  localparam int c_idx_w  = idx_width(LANES);
  localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(LANES - 1);
  localparam logic [ACC_BITS-1:0] c_acc_max  = '1;

  mac_state_e r_state;
  mac_state_e w_next;

  logic [c_cnt_w-1:0]  w_a_cnt [LANES];
  logic [c_cnt_w-1:0]  w_b_cnt [LANES];
  logic [c_idx_w-1:0]  r_idx;
  logic [ACC_BITS-1:0] r_acc;
  logic [ACC_BITS-1:0] r_down;
  logic                r_sat;
  logic                r_first;

  logic                w_beat;
  logic                w_out_hs;
  logic                w_last_beat;
  logic                w_done;
  logic [c_prod_w-1:0] w_prod;
  logic [c_sum_w-1:0]  w_sum;
  logic                w_over;
  logic [ACC_BITS-1:0] w_acc_add;

  assign w_beat      = in_valid && in_ready;
  assign w_out_hs    = out_valid && out_ready;
  assign w_last_beat = (r_down <= ACC_BITS'(1));
  assign w_done      = w_out_hs && w_last_beat;

  // One A and one B counter per lane; cleared together when a stream ends.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    unary_lane_counter #(.BIN_BITS(BIN_BITS)) u_cnt_a (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (w_done),
      .en     (w_beat),
      .bit_in (in_a[l]),
      .cnt    (w_a_cnt[l])
    );
    unary_lane_counter #(.BIN_BITS(BIN_BITS)) u_cnt_b (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (w_done),
      .en     (w_beat),
      .bit_in (in_b[l]),
      .cnt    (w_b_cnt[l])
    );
  end

  // Product of the lane selected this COMPUTE cycle, folded with saturation.
  always_comb begin
    w_prod    = c_prod_w'(w_a_cnt[r_idx]) * c_prod_w'(w_b_cnt[r_idx]);
    w_sum     = c_sum_w'(r_acc) + c_sum_w'(w_prod);
    w_over    = (w_sum > c_sum_w'(c_acc_max));
    w_acc_add = w_over ? c_acc_max : w_sum[ACC_BITS-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= LOAD;
    else          r_state <= w_next;
  end

  // Next-state and handshake/output decode.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out       = 1'b0;
    out_last  = 1'b0;
    out_sat   = 1'b0;
    case (r_state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_next = COMPUTE;
      end
      COMPUTE: begin
        if (r_idx == c_last_idx) w_next = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        out       = (r_down != '0);
        out_last  = w_last_beat;
        out_sat   = r_sat;
        if (out_ready && w_last_beat) w_next = LOAD;
      end
      default: w_next = LOAD;
    endcase
  end

  // Lane index walks 0..LANES-1 during COMPUTE, one product per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  r_idx <= '0;
    else if (r_state != COMPUTE)   r_idx <= '0;
    else if (r_idx == c_last_idx)  r_idx <= '0;
    else                           r_idx <= r_idx + 1'b1;
  end

  // First-beat tracker so in_acc is honoured only at the start of a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_first <= 1'b1;
    else if (w_beat) r_first <= in_last;
  end

  // Accumulator: optional clear on the first beat, saturating adds in COMPUTE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            r_acc <= '0;
    else if (w_beat && r_first && !in_acc)   r_acc <= '0;
    else if (r_state == COMPUTE)             r_acc <= w_acc_add;
  end

  // Sticky clip flag, dropped when the result stream completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        r_sat <= 1'b0;
    else if (w_done)                     r_sat <= 1'b0;
    else if (r_state == COMPUTE && w_over) r_sat <= 1'b1;
  end

  // Down-counter loaded with the final sum; the accumulator itself is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_down <= '0;
    end else if (r_state == COMPUTE && r_idx == c_last_idx) begin
      r_down <= w_acc_add;
    end else if (w_out_hs) begin
      r_down <= w_last_beat ? '0 : (r_down - 1'b1);
    end
  end

endmodule : unary_shift_mac
`default_nettype wire

// File: tb/tb_unary_shift_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unary_shift_mac
//  Description : Directed self-checking bench for unary_shift_mac.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unary_shift_mac;

  logic clk;
  logic reset_n;

  // Default-width instance (ACC_BITS = 12)
  logic       in_valid, in_last, in_acc, out_ready;
  logic [3:0] in_a, in_b;
  logic       in_ready, out, out_valid, out_last, out_sat;

  // Narrow-accumulator instance (ACC_BITS = 6)
  logic       in_valid_6, in_last_6, in_acc_6, out_ready_6;
  logic [3:0] in_a_6, in_b_6;
  logic       in_ready_6, out_6, out_valid_6, out_last_6, out_sat_6;

  int n_total;
  int n_bad;

  unary_shift_mac #(.BIN_BITS(4), .LANES(4), .ACC_BITS(12)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .in_acc(in_acc),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_sat(out_sat)
  );

  unary_shift_mac #(.BIN_BITS(4), .LANES(4), .ACC_BITS(6)) dut6 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_6), .in_ready(in_ready_6), .in_a(in_a_6), .in_b(in_b_6),
    .in_last(in_last_6), .in_acc(in_acc_6),
    .out(out_6), .out_valid(out_valid_6), .out_ready(out_ready_6),
    .out_last(out_last_6), .out_sat(out_sat_6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one frame; lane l of A carries a_v[l] leading ones. Starts and ends
  // on a negative edge; in_acc is inverted on non-first beats.
  task automatic send_frame(input bit sel, input logic [3:0][7:0] a_v,
                            input logic [3:0][7:0] b_v, input int nbeats,
                            input logic acc);
    for (int i = 0; i < nbeats; i++) begin
      logic [3:0] va;
      logic [3:0] vb;
      for (int l = 0; l < 4; l++) begin
        va[l] = (i < int'(a_v[l]));
        vb[l] = (i < int'(b_v[l]));
      end
      if (sel) begin
        in_valid_6 = 1'b1; in_a_6 = va; in_b_6 = vb;
        in_last_6 = (i == nbeats - 1); in_acc_6 = (i == 0) ? acc : ~acc;
      end else begin
        in_valid = 1'b1; in_a = va; in_b = vb;
        in_last = (i == nbeats - 1); in_acc = (i == 0) ? acc : ~acc;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; in_acc = 1'b0;
    in_valid_6 = 1'b0; in_a_6 = '0; in_b_6 = '0; in_last_6 = 1'b0; in_acc_6 = 1'b0;
  endtask

  // Gather the output stream. mode 0: always ready; mode 1: ready 1,0,0,...
  // stop_after > 0 ends collection after that many handshakes.
  task automatic collect(input bit sel, input int mode, input int stop_after,
                         output int ones, output int beats, output int lat,
                         output int stall_bad, output int inrdy_bad,
                         output bit sat_any, output bit sat_all,
                         output bit last_seen, output bit timeout);
    int cyc;
    bit prev_stall;
    logic p_out, p_last, p_sat;
    ones = 0; beats = 0; lat = 0; stall_bad = 0; inrdy_bad = 0;
    sat_any = 1'b0; sat_all = 1'b1; last_seen = 1'b0; timeout = 1'b0;
    prev_stall = 1'b0; p_out = 1'b0; p_last = 1'b0; p_sat = 1'b0;
    cyc = 0;
    while (!(sel ? out_valid_6 : out_valid) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      lat++;
    end
    if (!(sel ? out_valid_6 : out_valid)) begin
      timeout = 1'b1;
      return;
    end
    cyc = 0;
    while (!last_seen && cyc < 2000 && !(stop_after > 0 && beats >= stop_after)) begin
      logic v, o, lst, s, ir;
      bit rdy;
      v   = sel ? out_valid_6 : out_valid;
      o   = sel ? out_6       : out;
      lst = sel ? out_last_6  : out_last;
      s   = sel ? out_sat_6   : out_sat;
      ir  = sel ? in_ready_6  : in_ready;
      if (ir !== 1'b0) inrdy_bad++;
      if (v !== 1'b1) stall_bad++;
      if (prev_stall && (o !== p_out || lst !== p_last || s !== p_sat)) stall_bad++;
      rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (sel) out_ready_6 = rdy; else out_ready = rdy;
      if (v && rdy) begin
        beats++;
        ones += int'(o);
        sat_any = sat_any | s;
        sat_all = sat_all & s;
        if (lst) last_seen = 1'b1;
      end
      prev_stall = v && !rdy;
      p_out = o; p_last = lst; p_sat = s;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    out_ready_6 = 1'b0;
    if (!last_seen && stop_after == 0) timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n_total++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_total++;
    if (out_valid !== 1'b0 || out !== 1'b0 || out_last !== 1'b0 || out_sat !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b out=%b last=%b sat=%b want all 0",
               out_valid, out, out_last, out_sat);
    end
  endtask

  task automatic test_basic();
    int ones, beats, lat, sb, ib;
    bit sa, sl, ls, to;
    send_frame(0, {8'd0, 8'd0, 8'd0, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd5}, 5, 1'b0);
    collect(0, 0, 0, ones, beats, lat, sb, ib, sa, sl, ls, to);
    n_total++;
    if (to || !ls) begin n_bad++; $display("FAIL basic_timeout: got timeout=%b last=%b want 0/1", to, ls); end
    n_total++;
    if (lat != 4) begin n_bad++; $display("FAIL basic_latency: got %0d want 4 cycles after the in_last cycle+1", lat); end
    n_total++;
    if (ones != 15 || beats != 15) begin n_bad++; $display("FAIL basic_count: got ones=%0d beats=%0d want 15/15", ones, beats); end
    n_total++;
    if (sa !== 1'b0) begin n_bad++; $display("FAIL basic_sat: got %b want 0", sa); end
  endtask

  task automatic test_zero();
    int ones, beats, lat, sb, ib;
    bit sa, sl, ls, to;
    send_frame(0, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0}, 1, 1'b0);
    collect(0, 0, 0, ones, beats, lat, sb, ib, sa, sl, ls, to);
    n_total++;
    if (to || beats != 1 || ones != 0 || !ls) begin
      n_bad++;
      $display("FAIL zero_stream: got beats=%0d ones=%0d last=%b timeout=%b want 1/0/1/0", beats, ones, ls, to);
    end
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_return: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_accumulate();
    int ones, beats, lat, sb, ib;
    bit sa, sl, ls, to;
    send_frame(0, {8'd0, 8'd0, 8'd2, 8'd0}, {8'd0, 8'd0, 8'd2, 8'd0}, 2, 1'b0);
    collect(0, 0, 0, ones, beats, lat, sb, ib, sa, sl, ls, to);
    n_total++;
    if (to || ones != 4) begin n_bad++; $display("FAIL acc_frame1: got ones=%0d timeout=%b want 4", ones, to); end
    send_frame(0, {8'd0, 8'd3, 8'd0, 8'd0}, {8'd0, 8'd1, 8'd0, 8'd0}, 3, 1'b1);
    collect(0, 0, 0, ones, beats, lat, sb, ib, sa, sl, ls, to);
    n_total++;
    if (to || ones != 7) begin n_bad++; $display("FAIL acc_frame2: got ones=%0d timeout=%b want 7", ones, to); end
    send_frame(0, {8'd0, 8'd0, 8'd0, 8'd1}, {8'd0, 8'd0, 8'd0, 8'd1}, 1, 1'b0);
    collect(0, 0, 0, ones, beats, lat, sb, ib, sa, sl, ls, to);
    n_total++;
    if (to || ones != 1) begin n_bad++; $display("FAIL acc_frame3: got ones=%0d timeout=%b want 1", ones, to); end
  endtask

  task automatic test_backpressure();
    int ones, beats, lat, sb, ib;
    bit sa, sl, ls, to;
    send_frame(0, {8'd0, 8'd0, 8'd0, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd5}, 5, 1'b0);
    collect(0, 1, 0, ones, beats, lat, sb, ib, sa, sl, ls, to);
    n_total++;
    if (to || beats != 15 || ones != 15) begin
      n_bad++;
      $display("FAIL bp_count: got beats=%0d ones=%0d timeout=%b want 15/15/0", beats, ones, to);
    end
    n_total++;
    if (sb != 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable stalled beats want 0", sb); end
    n_total++;
    if (ib != 0) begin n_bad++; $display("FAIL bp_in_ready: got %0d cycles with in_ready high want 0", ib); end
  endtask

  task automatic test_saturation();
    int ones, beats, lat, sb, ib;
    bit sa, sl, ls, to;
    send_frame(1, {8'd20, 8'd20, 8'd20, 8'd20}, {8'd20, 8'd20, 8'd20, 8'd20}, 20, 1'b0);
    collect(1, 0, 0, ones, beats, lat, sb, ib, sa, sl, ls, to);
    n_total++;
    if (to || ones != 63 || beats != 63) begin
      n_bad++;
      $display("FAIL sat_count: got ones=%0d beats=%0d timeout=%b want 63/63/0", ones, beats, to);
    end
    n_total++;
    if (sl !== 1'b1) begin n_bad++; $display("FAIL sat_flag: got out_sat on every beat=%b want 1", sl); end
  endtask

  task automatic test_reset_midstream();
    int ones, beats, lat, sb, ib;
    bit sa, sl, ls, to;
    send_frame(0, {8'd0, 8'd0, 8'd0, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd5}, 5, 1'b0);
    collect(0, 0, 5, ones, beats, lat, sb, ib, sa, sl, ls, to);
    n_total++;
    if (beats != 5 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre: got beats=%0d out_valid=%b want 5/1", beats, out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_async: got out_valid=%b want 0", out_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    send_frame(0, {8'd0, 8'd0, 8'd0, 8'd1}, {8'd0, 8'd0, 8'd0, 8'd1}, 1, 1'b1);
    collect(0, 0, 0, ones, beats, lat, sb, ib, sa, sl, ls, to);
    n_total++;
    if (to || ones != 1 || beats != 1) begin
      n_bad++;
      $display("FAIL rst_after: got ones=%0d beats=%0d timeout=%b want 1/1/0", ones, beats, to);
    end
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    reset_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; in_acc = 1'b0; out_ready = 1'b0;
    in_valid_6 = 1'b0; in_a_6 = '0; in_b_6 = '0; in_last_6 = 1'b0; in_acc_6 = 1'b0; out_ready_6 = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero();
    test_accumulate();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_unary_shift_mac
`default_nettype wire
